stream_mux_rr: RTL and testbench
================================

STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning the number of input channels (legal range 2..16).
REQ-002 The block SHALL have parameter W, default 8, meaning the data width per channel in bits.
REQ-003 The block SHALL derive parameter SW = max(1, $clog2(N)), meaning the channel-index width.
REQ-004 Port clk  input  1  is the single clock; all state is rising-edge triggered.
REQ-005 Port rst_n  input  1  is the reset; it is asynchronous and active-low.
REQ-006 Port in_valid  input  N  carries per-channel valid; bit i belongs to channel i.
REQ-007 Port in_data  input  N*W  carries packed channel data; channel i occupies bits [i*W +: W].
REQ-008 Port in_ready  output  N  carries per-channel ready; at most one bit is high per cycle.
REQ-009 Port man_mode  input  1  selects the mode: 1 = manual select, 0 = round-robin arbitration.
REQ-010 Port man_sel  input  SW  is the channel index used when man_mode = 1.
REQ-011 Port out_valid  output  1  indicates that the output register holds data.
REQ-012 Port out_data  output  W  is the registered output data.
REQ-013 Port out_ch  output  SW  is the source channel index of out_data.
REQ-014 Port out_ready  input  1  is the downstream ready.
REQ-015 Port xfer_cnt  output  16  counts accepted input transfers and saturates at 16'hFFFF.

Function
REQ-016 The output stage SHALL be a single-entry register; a transfer occurs on a clock edge where load = (!out_valid || out_ready) and the granted channel is valid.
REQ-017 in_ready[g] SHALL equal load && grant_valid && (grant == g), and it SHALL be combinational from the current-cycle inputs and state.
REQ-018 The round-robin grant SHALL be the first channel with in_valid high, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
REQ-019 After a round-robin transfer from channel g, ptr SHALL become (g+1) mod N, wrapping from N-1 to 0.
REQ-020 ptr SHALL NOT change when no transfer occurs or when man_mode = 1.
REQ-021 In manual mode the grant SHALL be man_sel; grant_valid SHALL be in_valid[man_sel]; other channels SHALL never see in_ready high.
REQ-022 If man_sel >= N, grant_valid SHALL be 0 and no transfer SHALL occur.
REQ-023 On a transfer, out_data SHALL load in_data[g] and out_ch SHALL load g, and out_valid SHALL be 1 on the next cycle, giving a latency of 1 cycle.
REQ-024 When out_valid && out_ready is high and no new transfer occurs, out_valid SHALL clear on the next edge.
REQ-025 When an output is consumed and a new transfer occurs on the same edge, the new data SHALL load with no bubble, sustaining 1 transfer per cycle.
REQ-026 While out_valid && !out_ready, out_data and out_ch SHALL hold stable and all in_ready bits SHALL be 0.
REQ-027 A man_mode or man_sel change SHALL take effect in the same cycle it is applied; it SHALL NOT disturb the data already held in the output register.
REQ-028 xfer_cnt SHALL increment by 1 per transfer and SHALL hold at 16'hFFFF once reached.

Reset
REQ-029 While rst_n = 0, out_valid, out_data, out_ch, ptr and xfer_cnt SHALL be 0 and in_ready SHALL be all 0, regardless of clk.
REQ-030 Assertion of rst_n mid-transfer SHALL discard the held output immediately; operation SHALL resume on the first rising edge after rst_n = 1.

Verification
REQ-031 The bench SHALL cover round-robin with N=4, all in_valid=4'hF and out_ready=1: the out_ch sequence 0,1,2,3,0 is produced on consecutive cycles, and xfer_cnt=5.
REQ-032 The bench SHALL cover skip and wrap: with ptr=3 and in_valid=4'b0101, the grant goes to ch0 and the following grant to ch2.
REQ-033 The bench SHALL cover backpressure: with out_ready=0 for 3 cycles after a load of 8'hA5, out_data stays 8'hA5 and in_ready=0 throughout; out_ready=1 then releases the data, and the next channel is accepted on the same edge.
REQ-034 The bench SHALL cover manual mode: with man_mode=1, man_sel=2, in_valid=4'hF, only ch2 transfers, ptr is unchanged, and man_sel=5 with N=6 gives grant to ch5 while man_sel=7 gives no transfer.
REQ-035 The bench SHALL cover async reset: pulling rst_n low between clock edges while out_valid=1 forces out_valid=0 and xfer_cnt=0 before the next edge.
REQ-036 The bench SHALL cover saturation: with xfer_cnt preset near the limit by 65540 transfers, it reads 16'hFFFF and stays there.

Source files
------------

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with round-robin or manual selection
// and a single-entry registered output stage.
module stream_mux_rr #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = ($clog2(N) > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    in_ready,
  input  logic            man_mode,
  input  logic [SW-1:0]   man_sel,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_ch,
  input  logic            out_ready,
  output logic [15:0]     xfer_cnt
);

  logic [SW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] out_ch_q, out_ch_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic [15:0]   xfer_cnt_q, xfer_cnt_d;

  logic [SW-1:0] hi_grant, lo_grant, rr_grant, grant;
  logic          hi_valid, lo_valid, rr_valid, man_valid, grant_valid;
  logic [W-1:0]  grant_data;
  logic          load, xfer;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Round-robin: lowest valid channel at or above ptr, else lowest valid overall.
  always_comb begin
    hi_grant = '0;
    lo_grant = '0;
    hi_valid = 1'b0;
    lo_valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        lo_valid = 1'b1;
        lo_grant = SW'(i);
        if (SW'(i) >= ptr_q) begin
          hi_valid = 1'b1;
          hi_grant = SW'(i);
        end
      end
    end
    rr_grant = hi_valid ? hi_grant : lo_grant;
    rr_valid = lo_valid;
  end

  // Out-of-range man_sel matches no channel and therefore never grants.
  always_comb begin
    man_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (man_sel == SW'(i)) man_valid = in_valid[i];
    end
  end

  always_comb begin
    grant       = man_mode ? man_sel : rr_grant;
    grant_valid = man_mode ? man_valid : rr_valid;
    load        = !out_valid_q || out_ready;
    xfer        = load && grant_valid;
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SW'(i)) grant_data = in_data[i*W +: W];
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      in_ready[i] = rst_n && xfer && (grant == SW'(i));
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    xfer_cnt_d  = xfer_cnt_q;
    if (xfer) begin
      out_ch_d    = grant;
      out_data_d  = grant_data;
      out_valid_d = 1'b1;
      xfer_cnt_d  = sat_inc(xfer_cnt_q);
      if (!man_mode) begin
        ptr_d = (rr_grant == SW'(N - 1)) ? '0 : rr_grant + SW'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      xfer_cnt_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a 4-channel instance for the main flows
// and a 6-channel instance for out-of-range manual selection.
module tb_stream_mux_rr;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [3:0]  in_valid4, in_ready4;
  logic [31:0] in_data4;
  logic        man_mode4, out_valid4, out_ready4;
  logic [1:0]  man_sel4, out_ch4;
  logic [7:0]  out_data4;
  logic [15:0] xfer_cnt4;

  logic [5:0]  in_valid6, in_ready6;
  logic [47:0] in_data6;
  logic        man_mode6, out_valid6, out_ready6;
  logic [2:0]  man_sel6, out_ch6;
  logic [7:0]  out_data6;
  logic [15:0] xfer_cnt6;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  stream_mux_rr #(.N(4), .W(8)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_data(in_data4),
    .in_ready(in_ready4), .man_mode(man_mode4), .man_sel(man_sel4),
    .out_valid(out_valid4), .out_data(out_data4), .out_ch(out_ch4),
    .out_ready(out_ready4), .xfer_cnt(xfer_cnt4)
  );

  stream_mux_rr #(.N(6), .W(8)) u6 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid6), .in_data(in_data6),
    .in_ready(in_ready6), .man_mode(man_mode6), .man_sel(man_sel6),
    .out_valid(out_valid6), .out_data(out_data6), .out_ch(out_ch6),
    .out_ready(out_ready6), .xfer_cnt(xfer_cnt6)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid4 = 4'hF; in_data4 = 32'h13121110; man_mode4 = 1'b0; man_sel4 = 2'd0; out_ready4 = 1'b1;
    in_valid6 = 6'h00; in_data6 = 48'h656463626160; man_mode6 = 1'b0; man_sel6 = 3'd0; out_ready6 = 1'b1;
    #7;
    vectors++; if (out_valid4 !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b exp=0", out_valid4); end
    vectors++; if (out_data4 !== 8'h00) begin miscompares++; $display("FAIL reset_out_data got=%h exp=00", out_data4); end
    vectors++; if (out_ch4 !== 2'd0) begin miscompares++; $display("FAIL reset_out_ch got=%0d exp=0", out_ch4); end
    vectors++; if (xfer_cnt4 !== 16'd0) begin miscompares++; $display("FAIL reset_xfer_cnt got=%0d exp=0", xfer_cnt4); end
    vectors++; if (in_ready4 !== 4'b0000) begin miscompares++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready4); end
    in_valid4 = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    in_valid4 = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1;
      vectors++; if (in_ready4 !== 4'(1 << (k % 4))) begin miscompares++; $display("FAIL rr_in_ready[%0d] got=%b exp=%b", k, in_ready4, 4'(1 << (k % 4))); end
      tick();
      vectors++; if (out_valid4 !== 1'b1 || out_ch4 !== 2'(k % 4) || out_data4 !== 8'(8'h10 + k % 4)) begin
        miscompares++; $display("FAIL rr_out[%0d] got v=%b ch=%0d d=%h exp v=1 ch=%0d d=%h", k, out_valid4, out_ch4, out_data4, k % 4, 8'(8'h10 + k % 4));
      end
    end
    vectors++; if (xfer_cnt4 !== 16'd5) begin miscompares++; $display("FAIL rr_xfer_cnt got=%0d exp=5", xfer_cnt4); end
    in_valid4 = 4'h0;
    tick();
    vectors++; if (out_valid4 !== 1'b0) begin miscompares++; $display("FAIL rr_drain got=%b exp=0", out_valid4); end
  endtask

  task automatic test_skip_wrap();
    in_valid4 = 4'b0100;
    tick();
    in_valid4 = 4'b0101;
    #1;
    vectors++; if (in_ready4 !== 4'b0001) begin miscompares++; $display("FAIL wrap_in_ready got=%b exp=0001", in_ready4); end
    tick();
    vectors++; if (out_ch4 !== 2'd0 || out_data4 !== 8'h10) begin miscompares++; $display("FAIL wrap_out got ch=%0d d=%h exp ch=0 d=10", out_ch4, out_data4); end
    vectors++; if (in_ready4 !== 4'b0100) begin miscompares++; $display("FAIL skip_in_ready got=%b exp=0100", in_ready4); end
    tick();
    vectors++; if (out_ch4 !== 2'd2 || out_data4 !== 8'h12) begin miscompares++; $display("FAIL skip_out got ch=%0d d=%h exp ch=2 d=12", out_ch4, out_data4); end
    in_valid4 = 4'h0;
    tick();
    vectors++; if (xfer_cnt4 !== 16'd8) begin miscompares++; $display("FAIL skip_xfer_cnt got=%0d exp=8", xfer_cnt4); end
  endtask

  task automatic test_backpressure();
    in_data4[31:24] = 8'hA5;
    in_valid4 = 4'b1000;
    tick();
    vectors++; if (out_data4 !== 8'hA5 || out_ch4 !== 2'd3) begin miscompares++; $display("FAIL bp_load got ch=%0d d=%h exp ch=3 d=a5", out_ch4, out_data4); end
    out_ready4 = 1'b0;
    in_valid4 = 4'hF;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++; if (in_ready4 !== 4'b0000) begin miscompares++; $display("FAIL bp_in_ready[%0d] got=%b exp=0000", k, in_ready4); end
      tick();
      vectors++; if (out_valid4 !== 1'b1 || out_data4 !== 8'hA5 || out_ch4 !== 2'd3) begin
        miscompares++; $display("FAIL bp_hold[%0d] got v=%b ch=%0d d=%h exp v=1 ch=3 d=a5", k, out_valid4, out_ch4, out_data4);
      end
    end
    out_ready4 = 1'b1;
    #1;
    vectors++; if (in_ready4 !== 4'b0001) begin miscompares++; $display("FAIL bp_release_ready got=%b exp=0001", in_ready4); end
    tick();
    vectors++; if (out_valid4 !== 1'b1 || out_ch4 !== 2'd0 || out_data4 !== 8'h10) begin
      miscompares++; $display("FAIL bp_release got v=%b ch=%0d d=%h exp v=1 ch=0 d=10", out_valid4, out_ch4, out_data4);
    end
    in_valid4 = 4'h0;
    in_data4[31:24] = 8'h13;
    tick();
    vectors++; if (xfer_cnt4 !== 16'd10) begin miscompares++; $display("FAIL bp_xfer_cnt got=%0d exp=10", xfer_cnt4); end
  endtask

  task automatic test_manual();
    man_mode4 = 1'b1; man_sel4 = 2'd2; in_valid4 = 4'hF;
    #1;
    vectors++; if (in_ready4 !== 4'b0100) begin miscompares++; $display("FAIL man_in_ready got=%b exp=0100", in_ready4); end
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++; if (out_ch4 !== 2'd2 || out_data4 !== 8'h12) begin miscompares++; $display("FAIL man_out[%0d] got ch=%0d d=%h exp ch=2 d=12", k, out_ch4, out_data4); end
    end
    man_mode4 = 1'b0;
    #1;
    vectors++; if (in_ready4 !== 4'b0010) begin miscompares++; $display("FAIL man_ptr_kept got=%b exp=0010", in_ready4); end
    tick();
    vectors++; if (out_ch4 !== 2'd1 || xfer_cnt4 !== 16'd14) begin miscompares++; $display("FAIL man_back_rr got ch=%0d cnt=%0d exp ch=1 cnt=14", out_ch4, xfer_cnt4); end
    out_ready4 = 1'b0; man_mode4 = 1'b1; man_sel4 = 2'd3;
    #1;
    vectors++; if (in_ready4 !== 4'b0000) begin miscompares++; $display("FAIL man_switch_ready got=%b exp=0000", in_ready4); end
    tick();
    vectors++; if (out_ch4 !== 2'd1 || out_data4 !== 8'h11) begin miscompares++; $display("FAIL man_switch_hold got ch=%0d d=%h exp ch=1 d=11", out_ch4, out_data4); end
    out_ready4 = 1'b1;
    #1;
    vectors++; if (in_ready4 !== 4'b1000) begin miscompares++; $display("FAIL man_sel3_ready got=%b exp=1000", in_ready4); end
    tick();
    vectors++; if (out_ch4 !== 2'd3 || xfer_cnt4 !== 16'd15) begin miscompares++; $display("FAIL man_sel3_out got ch=%0d cnt=%0d exp ch=3 cnt=15", out_ch4, xfer_cnt4); end
    in_valid4 = 4'h0; man_mode4 = 1'b0;
    tick();
  endtask

  task automatic test_manual_n6();
    in_valid6 = 6'h3F; man_mode6 = 1'b1; man_sel6 = 3'd5;
    #1;
    vectors++; if (in_ready6 !== 6'b100000) begin miscompares++; $display("FAIL n6_sel5_ready got=%b exp=100000", in_ready6); end
    tick();
    vectors++; if (out_valid6 !== 1'b1 || out_ch6 !== 3'd5 || out_data6 !== 8'h65) begin
      miscompares++; $display("FAIL n6_sel5_out got v=%b ch=%0d d=%h exp v=1 ch=5 d=65", out_valid6, out_ch6, out_data6);
    end
    man_sel6 = 3'd7;
    #1;
    vectors++; if (in_ready6 !== 6'b000000) begin miscompares++; $display("FAIL n6_sel7_ready got=%b exp=000000", in_ready6); end
    tick();
    vectors++; if (out_valid6 !== 1'b0 || xfer_cnt6 !== 16'd1) begin miscompares++; $display("FAIL n6_sel7_out got v=%b cnt=%0d exp v=0 cnt=1", out_valid6, xfer_cnt6); end
    in_valid6 = 6'h00; man_mode6 = 1'b0;
  endtask

  task automatic test_async_reset();
    in_valid4 = 4'hF;
    tick();
    vectors++; if (out_valid4 !== 1'b1 || out_ch4 !== 2'd2 || xfer_cnt4 !== 16'd16) begin
      miscompares++; $display("FAIL ar_pre got v=%b ch=%0d cnt=%0d exp v=1 ch=2 cnt=16", out_valid4, out_ch4, xfer_cnt4);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (out_valid4 !== 1'b0 || xfer_cnt4 !== 16'd0 || out_data4 !== 8'h00) begin
      miscompares++; $display("FAIL ar_mid got v=%b cnt=%0d d=%h exp v=0 cnt=0 d=00", out_valid4, xfer_cnt4, out_data4);
    end
    vectors++; if (in_ready4 !== 4'b0000) begin miscompares++; $display("FAIL ar_in_ready got=%b exp=0000", in_ready4); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    vectors++; if (out_valid4 !== 1'b1 || out_ch4 !== 2'd0 || xfer_cnt4 !== 16'd1) begin
      miscompares++; $display("FAIL ar_resume got v=%b ch=%0d cnt=%0d exp v=1 ch=0 cnt=1", out_valid4, out_ch4, xfer_cnt4);
    end
  endtask

  task automatic test_saturation();
    repeat (65533) @(posedge clk);
    #1;
    vectors++; if (xfer_cnt4 !== 16'hFFFE) begin miscompares++; $display("FAIL sat_near got=%h exp=fffe", xfer_cnt4); end
    tick();
    vectors++; if (xfer_cnt4 !== 16'hFFFF) begin miscompares++; $display("FAIL sat_reach got=%h exp=ffff", xfer_cnt4); end
    repeat (5) @(posedge clk);
    #1;
    vectors++; if (xfer_cnt4 !== 16'hFFFF || out_valid4 !== 1'b1) begin
      miscompares++; $display("FAIL sat_hold got cnt=%h v=%b exp cnt=ffff v=1", xfer_cnt4, out_valid4);
    end
    in_valid4 = 4'h0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_skip_wrap();
    test_backpressure();
    test_manual();
    test_manual_n6();
    test_async_reset();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
